// File: rtl/memacc_pkg.sv
// Shared types and helpers for the memacc load/store controller.
// The optional MEMACC_ALIGN_CHECK_EN build uses misaligned(); align_down() serves the default build.
package memacc_pkg;

  localparam int N = 64;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    WORD  = 2'd1,
    RSVD  = 2'd2,
    DWORD = 2'd3
  } size_e;

  localparam logic [1:0] MW_NONE = 2'd0;
  localparam logic [1:0] MW_W    = 2'd1;
  localparam logic [1:0] MW_B    = 2'd2;
  localparam logic [1:0] MW_D    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } memacc_state_e;

  // The memory's write code differs from the request size code for bytes.
  function automatic logic [1:0] size_to_mw(size_e s);
    case (s)
      BYTE:    return MW_B;
      WORD:    return MW_W;
      DWORD:   return MW_D;
      default: return MW_NONE;
    endcase
  endfunction

  function automatic logic [N-1:0] align_down(logic [N-1:0] a, size_e s);
    case (s)
      WORD:    return {a[N-1:2], 2'b00};
      DWORD:   return {a[N-1:3], 3'b000};
      default: return a;
    endcase
  endfunction

  function automatic logic misaligned(logic [N-1:0] a, size_e s);
    case (s)
      WORD:    return a[1:0] != 2'b00;
      DWORD:   return a[2:0] != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memacc_extract.sv
// Load-data extraction: picks the big-endian byte/word out of the memory read data
// and zero- or sign-extends it to 64 bits.
module memacc_extract
  import memacc_pkg::*;
(
  input  logic [N-1:0] readdata_i,
  input  logic [1:0]   addr_i,
  input  logic [1:0]   size_i,
  input  logic         unsigned_i,
  output logic [N-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [31:0] word_v;

  always_comb begin
    word_v = readdata_i[31:0];
    byte_v = 8'h00;
    // Word half is already chosen by addr[2]; offset 0 is the most significant byte.
    case (addr_i)
      2'd0:    byte_v = word_v[31:24];
      2'd1:    byte_v = word_v[23:16];
      2'd2:    byte_v = word_v[15:8];
      default: byte_v = word_v[7:0];
    endcase

    data_o = readdata_i;
    case (size_e'(size_i))
      BYTE:    data_o = unsigned_i ? {56'd0, byte_v} : {{56{byte_v[7]}}, byte_v};
      WORD:    data_o = unsigned_i ? {32'd0, word_v} : {{32{word_v[31]}}, word_v};
      default: data_o = readdata_i;
    endcase
  end

endmodule

// File: rtl/memacc_unit.sv
// Load/store controller between the memory stage and the 64-bit big-endian data memory.
// Optional build macro MEMACC_ALIGN_CHECK_EN rejects misaligned word/dword accesses.
//
// state    | meaning
// S_IDLE   | waiting for a request, memory ports quiet
// S_ACCESS | memory ports driven for exactly this cycle
// S_DONE   | resp_valid high; may accept the next request
module memacc_unit
  import memacc_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic         req_write_i,
  input  logic [1:0]   req_size_i,
  input  logic         req_unsigned_i,
  input  logic [N-1:0] req_addr_i,
  input  logic [N-1:0] req_wdata_i,
  output logic         resp_valid_o,
  output logic [N-1:0] resp_rdata_o,
  output logic         resp_err_o,
  output logic         mem_readtype_o,
  output logic [1:0]   mem_memwrite_o,
  output logic [N-1:0] mem_dataadr_o,
  output logic [N-1:0] mem_writedata_o,
  input  logic [N-1:0] mem_readdata_i
);

  memacc_state_e state_q;
  logic          ready_q, resp_valid_q, resp_err_q, readtype_q;
  logic          legal_q, write_q, uns_q;
  logic [1:0]    size_q, memwrite_q, memwrite_d;
  logic [N-1:0]  rdata_q, rdata_d, dataadr_q, wdata_q, ext_data;
  logic          accept, req_legal;
  logic [N-1:0]  req_adr;
  size_e         req_size;

  assign req_size = size_e'(req_size_i);
  assign accept   = req_valid_i & ready_q;

`ifdef MEMACC_ALIGN_CHECK_EN
  assign req_legal = (req_size != RSVD) && !misaligned(req_addr_i, req_size);
  assign req_adr   = req_addr_i;
`else
  assign req_legal = (req_size != RSVD);
  assign req_adr   = align_down(req_addr_i, req_size);
`endif

  assign memwrite_d = (req_write_i && req_legal) ? size_to_mw(req_size) : MW_NONE;
  assign rdata_d    = (legal_q && !write_q) ? ext_data : '0;

  memacc_extract u_extract (
    .readdata_i (mem_readdata_i),
    .addr_i     (dataadr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      readtype_q   <= 1'b1;
      memwrite_q   <= MW_NONE;
      dataadr_q    <= '0;
      wdata_q      <= '0;
      legal_q      <= 1'b0;
      write_q      <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          if (accept) begin
            dataadr_q  <= req_adr;
            wdata_q    <= req_wdata_i;
            readtype_q <= (req_size == DWORD);
            memwrite_q <= memwrite_d;
            legal_q    <= req_legal;
            write_q    <= req_write_i;
            uns_q      <= req_unsigned_i;
            size_q     <= req_size_i;
            ready_q    <= 1'b0;
            state_q    <= S_ACCESS;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ACCESS: begin
          memwrite_q   <= MW_NONE;
          readtype_q   <= 1'b1;
          rdata_q      <= rdata_d;
          resp_err_q   <= !legal_q;
          resp_valid_q <= 1'b1;
          ready_q      <= 1'b1;
          state_q      <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o     = ready_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_rdata_o    = rdata_q;
  assign resp_err_o      = resp_err_q;
  assign mem_readtype_o  = readtype_q;
  assign mem_memwrite_o  = memwrite_q;
  assign mem_dataadr_o   = dataadr_q;
  assign mem_writedata_o = wdata_q;

endmodule

// File: tb/tb_memacc_unit.sv
// Scoreboard bench for memacc_unit: byte-array reference model, 8-word memory, random traffic.
module tb_memacc_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_readtype;
  logic [63:0] resp_rdata, mem_dataadr, mem_writedata, mem_readdata;
  logic [1:0]  mem_memwrite;

  always #5 clk = ~clk;

  memacc_unit dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err), .mem_readtype_o(mem_readtype), .mem_memwrite_o(mem_memwrite),
    .mem_dataadr_o(mem_dataadr), .mem_writedata_o(mem_writedata), .mem_readdata_i(mem_readdata)
  );

  // Data memory: 8 big-endian 64-bit words, combinational read, write on the clock edge.
  logic [63:0] mem [8];
  logic [63:0] preload_img [8];
  logic        preload_en = 1'b0;

  always_comb begin
    if (mem_readtype) mem_readdata = mem[mem_dataadr[5:3]];
    else mem_readdata = {32'd0, mem_dataadr[2] ? mem[mem_dataadr[5:3]][31:0]
                                               : mem[mem_dataadr[5:3]][63:32]};
  end

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < 8; i++) mem[i] <= preload_img[i];
    end else begin
      case (mem_memwrite)
        2'd1: if (mem_dataadr[2]) mem[mem_dataadr[5:3]][31:0] <= mem_writedata[31:0];
              else mem[mem_dataadr[5:3]][63:32] <= mem_writedata[31:0];
        2'd2: mem[mem_dataadr[5:3]][63-8*int'(mem_dataadr[2:0]) -: 8] <= mem_writedata[7:0];
        2'd3: mem[mem_dataadr[5:3]] <= mem_writedata;
        default: ;
      endcase
    end
  end

  // Reference model: flat byte array, byte address a holds byte a (big-endian).
  logic [7:0] mb [64];

  typedef struct { logic [63:0] rdata; logic err; } resp_t;
  resp_t exp_q [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual=%h required=none", resp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic issue(bit wr, int sz, bit uns, logic [63:0] a, logic [63:0] wd, bit b2b);
    int          nb;
    bit          legal;
    logic [63:0] ae, v, mw;
    resp_t       e;
    nb = (sz == 0) ? 1 : (sz == 1) ? 4 : 8;
    legal = (sz != 2);
`ifdef MEMACC_ALIGN_CHECK_EN
    if (sz != 2 && (a % nb) != 0) legal = 0;
    ae = a;
`else
    ae = (sz == 2) ? a : a - (a % nb);
`endif
    v = 0;
    if (legal && !wr) begin
      for (int i = 0; i < nb; i++) v = (v << 8) | 64'(mb[int'(ae) + i]);
      if (!uns && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 1);
    end
    if (legal && wr)
      for (int i = 0; i < nb; i++) mb[int'(ae) + i] = 8'(wd >> (8*(nb-1-i)));
    mw = (!legal || !wr) ? 0 : (sz == 0) ? 2 : (sz == 1) ? 1 : 3;
    e.rdata = v; e.err = !legal;
    exp_q.push_back(e);

    req_valid = 1; req_write = wr; req_size = 2'(sz); req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // Junk on the request port while busy must be ignored.
    req_valid = 1'($urandom); req_write = 1'($urandom); req_size = 2'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    chk("ready_in_access", {63'd0, req_ready}, 64'd0);
    chk("memwrite_access", {62'd0, mem_memwrite}, mw);
    chk("readtype_access", {63'd0, mem_readtype}, {63'd0, sz == 3});
    chk("dataadr_access", mem_dataadr, ae);
    if (wr) chk("writedata_access", mem_writedata, wd);
    @(posedge clk); #1;
    req_valid = 0;
    chk("memwrite_done", {62'd0, mem_memwrite}, 64'd0);
    chk("readtype_done", {63'd0, mem_readtype}, 64'd1);
    chk("ready_done", {63'd0, req_ready}, 64'd1);
    if (!b2b) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  logic [63:0] w;

  initial begin
    reset_n = 0; req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 8; i++) preload_img[i] = {$urandom, $urandom};
    preload_img[2] = 64'h8899AABB_CCDDEEFF;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++) mb[8*i+k] = 8'(preload_img[i] >> (56 - 8*k));
    preload_en = 1;
    @(posedge clk); #1;
    preload_en = 0;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_memwrite", {62'd0, mem_memwrite}, 64'd0);
    chk("rst_readtype", {63'd0, mem_readtype}, 64'd1);
    chk("rst_dataadr", mem_dataadr, 64'd0);
    chk("rst_writedata", mem_writedata, 64'd0);
    reset_n = 1;
    @(posedge clk); #1;

    issue(0, 0, 0, 64'h10, 0, 0);
    issue(0, 0, 1, 64'h13, 0, 0);
    issue(0, 1, 0, 64'h14, 0, 0);
    issue(0, 1, 1, 64'h10, 0, 0);
    issue(1, 0, 0, 64'h17, 64'h5A, 0);
    issue(0, 3, 0, 64'h10, 0, 0);
    issue(1, 3, 0, 64'h18, 64'h01234567_89ABCDEF, 1);
    issue(0, 3, 0, 64'h18, 0, 0);
    issue(1, 1, 0, 64'h12, 64'hCAFEF00D_DEADBEEF, 0);
    issue(0, 3, 0, 64'h10, 0, 0);
    issue(0, 2, 0, 64'h08, 0, 1);
    issue(1, 2, 0, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    issue(0, 3, 0, 64'h20, 0, 0);

    for (int n = 0; n < 300; n++)
      issue(1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
            64'($urandom_range(0, 63)), {$urandom, $urandom}, 1'($urandom));

    // Reset during ACCESS of a dword store: write suppressed, no response.
    req_valid = 1; req_write = 1; req_size = 2'd3; req_unsigned = 0;
    req_addr = 64'h18; req_wdata = 64'hA5A5_5A5A_F00D_BEEF;
    @(posedge clk); #1;
    req_valid = 0;
    chk("rstmid_memwrite_before", {62'd0, mem_memwrite}, 64'd3);
    #2 reset_n = 0;
    #1;
    chk("rstmid_memwrite_async", {62'd0, mem_memwrite}, 64'd0);
    chk("rstmid_ready", {63'd0, req_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_idle_ready", {63'd0, req_ready}, 64'd1);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 8; i++) begin
      w = 0;
      for (int k = 0; k < 8; k++) w = (w << 8) | 64'(mb[8*i+k]);
      chk($sformatf("mem_word_%0d", i), mem[i], w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
